// File: rtl/fb_frame_sequencer.sv
// Double-buffered framebuffer frame sequencer: clear, draw gating, vsync-aligned swap.
// Optional clear pass enabled by defining FB_SEQ_CLEAR_EN.
module fb_frame_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned NUM_PIXELS  = 76800,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vsync_i,
  input  logic                  rast_valid_i,
  output logic                  rast_ready_o,
  input  logic [ADDR_WIDTH-1:0] rast_addr_i,
  input  logic [7:0]            rast_data_i,
  input  logic                  frame_done_i,
  output logic                  fb_wea_o,
  output logic [ADDR_WIDTH-1:0] fb_addra_o,
  output logic [7:0]            fb_dina_o,
  output logic                  front_sel_o,
  output logic                  swap_pulse_o,
  output logic                  frame_busy_o,
  output logic [7:0]            dropped_frames_o
);

  typedef enum logic [1:0] {
    S_CLEAR      = 2'd0,
    S_DRAW       = 2'd1,
    S_WAIT_VSYNC = 2'd2,
    S_SWAP       = 2'd3
  } state_e;

`ifdef FB_SEQ_CLEAR_EN
  localparam state_e START_STATE = S_CLEAR;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
`else
  localparam state_e START_STATE = S_DRAW;
  logic unused_cfg;
  assign unused_cfg = ^{NUM_PIXELS, CLEAR_COLOR};
`endif

  state_e                state_q;
  logic                  vs_meta_q, vs_sync_q, vs_prev_q;
  logic                  fb_wea_q;
  logic [ADDR_WIDTH-1:0] fb_addra_q;
  logic [7:0]            fb_dina_q;
  logic                  front_sel_q;
  logic                  swap_pulse_q;
  logic [7:0]            dropped_q;
  logic [7:0]            dropped_d;
  logic                  vs_fall;

  assign vs_fall   = vs_prev_q & ~vs_sync_q;
  assign dropped_d = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= START_STATE;
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      fb_wea_q     <= 1'b0;
      fb_addra_q   <= '0;
      fb_dina_q    <= 8'h00;
      front_sel_q  <= 1'b0;
      swap_pulse_q <= 1'b0;
      dropped_q    <= 8'h00;
`ifdef FB_SEQ_CLEAR_EN
      clr_cnt_q    <= '0;
`endif
    end else begin
      vs_meta_q    <= vsync_i;
      vs_sync_q    <= vs_meta_q;
      vs_prev_q    <= vs_sync_q;
      fb_wea_q     <= 1'b0;
      swap_pulse_q <= 1'b0;

      // A vsync edge that finds the frame still in progress is a dropped frame.
      if (vs_fall && (state_q == S_CLEAR || state_q == S_DRAW)) begin
        dropped_q <= dropped_d;
      end

      case (state_q)
`ifdef FB_SEQ_CLEAR_EN
        S_CLEAR: begin
          fb_wea_q   <= 1'b1;
          fb_addra_q <= clr_cnt_q;
          fb_dina_q  <= CLEAR_COLOR;
          if (clr_cnt_q == ADDR_WIDTH'(NUM_PIXELS - 1)) begin
            clr_cnt_q <= '0;
            state_q   <= S_DRAW;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          end
        end
`endif
        S_DRAW: begin
          if (rast_valid_i) begin
            fb_wea_q   <= 1'b1;
            fb_addra_q <= rast_addr_i;
            fb_dina_q  <= rast_data_i;
          end
          if (frame_done_i) begin
            state_q <= S_WAIT_VSYNC;
          end
        end
        // Toggle on entry so front_sel and swap_pulse change during the SWAP cycle.
        S_WAIT_VSYNC: begin
          if (vs_fall) begin
            state_q      <= S_SWAP;
            front_sel_q  <= ~front_sel_q;
            swap_pulse_q <= 1'b1;
          end
        end
        S_SWAP: begin
          state_q <= START_STATE;
        end
        default: begin
          state_q <= START_STATE;
        end
      endcase
    end
  end

  assign rast_ready_o     = (state_q == S_DRAW);
  assign frame_busy_o     = (state_q == S_CLEAR) || (state_q == S_DRAW);
  assign fb_wea_o         = fb_wea_q;
  assign fb_addra_o       = fb_addra_q;
  assign fb_dina_o        = fb_dina_q;
  assign front_sel_o      = front_sel_q;
  assign swap_pulse_o     = swap_pulse_q;
  assign dropped_frames_o = dropped_q;

endmodule

// File: tb/tb_fb_frame_sequencer.sv
// Directed bench for fb_frame_sequencer with a 16-pixel buffer; adapts to FB_SEQ_CLEAR_EN.
module tb_fb_frame_sequencer;

  localparam int unsigned AW   = 17;
  localparam int unsigned NPIX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          rast_valid;
  logic          rast_ready;
  logic [AW-1:0] rast_addr;
  logic [7:0]    rast_data;
  logic          frame_done;
  logic          fb_wea;
  logic [AW-1:0] fb_addra;
  logic [7:0]    fb_dina;
  logic          front_sel;
  logic          swap_pulse;
  logic          frame_busy;
  logic [7:0]    dropped;

  int checks = 0;
  int errors = 0;

  fb_frame_sequencer #(
    .ADDR_WIDTH (AW),
    .NUM_PIXELS (NPIX),
    .CLEAR_COLOR(8'h00)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .vsync_i         (vsync),
    .rast_valid_i    (rast_valid),
    .rast_ready_o    (rast_ready),
    .rast_addr_i     (rast_addr),
    .rast_data_i     (rast_data),
    .frame_done_i    (frame_done),
    .fb_wea_o        (fb_wea),
    .fb_addra_o      (fb_addra),
    .fb_dina_o       (fb_dina),
    .front_sel_o     (front_sel),
    .swap_pulse_o    (swap_pulse),
    .frame_busy_o    (frame_busy),
    .dropped_frames_o(dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects the FSM to be in CLEAR with clr_cnt = 0 before the first edge.
  task automatic run_clear(input logic fd);
    frame_done = fd;
    for (int k = 0; k < int'(NPIX); k++) begin
      tick();
      chk("clr_wea", 32'(fb_wea), 32'd1);
      chk("clr_addr", 32'(fb_addra), 32'(k));
      chk("clr_data", 32'(fb_dina), 32'h00);
      chk("clr_ready", 32'(rast_ready), (k == int'(NPIX) - 1) ? 32'd1 : 32'd0);
    end
    frame_done = 1'b0;
    chk("clr_busy_end", 32'(frame_busy), 32'd1);
  endtask

  // Starts in DRAW; ends one cycle after SWAP.
  task automatic do_swap(input logic exp_front);
    rast_valid = 1'b0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    vsync = 1'b0;
    tick();
    tick();
    tick();
    chk("ds_swap", 32'(swap_pulse), 32'd1);
    chk("ds_front", 32'(front_sel), 32'(exp_front));
    vsync = 1'b1;
    tick();
    chk("ds_swap_end", 32'(swap_pulse), 32'd0);
  endtask

  task automatic vs_pulse();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b1; rast_valid = 1'b0; rast_addr = '0; rast_data = 8'h00; frame_done = 1'b0;
    tick();
    tick();
    chk("rst_wea", 32'(fb_wea), 32'd0);
    chk("rst_addr", 32'(fb_addra), 32'd0);
    chk("rst_data", 32'(fb_dina), 32'd0);
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_swap", 32'(swap_pulse), 32'd0);
    chk("rst_drop", 32'(dropped), 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd1);
`ifdef FB_SEQ_CLEAR_EN
    chk("rst_ready", 32'(rast_ready), 32'd0);
    rst = 1'b0;
    run_clear(1'b0);
`else
    chk("rst_ready", 32'(rast_ready), 32'd1);
    rst = 1'b0;
    tick();
    chk("nc_ready_first", 32'(rast_ready), 32'd1);
    chk("nc_no_wr", 32'(fb_wea), 32'd0);
`endif

    // Draw: idle, normal write, out-of-range address, last write with frame_done.
    tick();
    chk("draw_idle_wea", 32'(fb_wea), 32'd0);
    rast_valid = 1'b1; rast_addr = 17'd5; rast_data = 8'hA7;
    tick();
    chk("draw_wea", 32'(fb_wea), 32'd1);
    chk("draw_addr", 32'(fb_addra), 32'd5);
    chk("draw_data", 32'(fb_dina), 32'hA7);
    chk("draw_ready", 32'(rast_ready), 32'd1);
    rast_addr = 17'h1FFFF; rast_data = 8'h5A;
    tick();
    chk("oor_addr", 32'(fb_addra), 32'h1FFFF);
    chk("oor_data", 32'(fb_dina), 32'h5A);
    rast_addr = 17'd6; rast_data = 8'h3C; frame_done = 1'b1;
    tick();
    chk("last_wea", 32'(fb_wea), 32'd1);
    chk("last_addr", 32'(fb_addra), 32'd6);
    chk("last_data", 32'(fb_dina), 32'h3C);
    chk("last_ready", 32'(rast_ready), 32'd0);
    chk("last_busy", 32'(frame_busy), 32'd0);
    frame_done = 1'b0; rast_addr = 17'd7; rast_data = 8'h11;
    tick();
    chk("wait_no_wr", 32'(fb_wea), 32'd0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    chk("wait_wea", 32'(fb_wea), 32'd0);
    chk("wait_busy", 32'(frame_busy), 32'd0);
    chk("wait_swap", 32'(swap_pulse), 32'd0);
    rast_valid = 1'b0;

    // Vsync fall in WAIT_VSYNC: swap appears on the third edge.
    vsync = 1'b0;
    tick();
    chk("sw_e1", 32'(swap_pulse), 32'd0);
    tick();
    chk("sw_e2", 32'(swap_pulse), 32'd0);
    chk("sw_e2_front", 32'(front_sel), 32'd0);
    tick();
    chk("sw_pulse", 32'(swap_pulse), 32'd1);
    chk("sw_front", 32'(front_sel), 32'd1);
    chk("sw_wea", 32'(fb_wea), 32'd0);
    chk("sw_busy", 32'(frame_busy), 32'd0);
    vsync = 1'b1;
    tick();
    chk("sw_pulse_end", 32'(swap_pulse), 32'd0);
    chk("sw_front_hold", 32'(front_sel), 32'd1);
    chk("sw_post_wea", 32'(fb_wea), 32'd0);
`ifdef FB_SEQ_CLEAR_EN
    chk("sw_post_ready", 32'(rast_ready), 32'd0);
    run_clear(1'b1);
    tick();
    chk("fd_ignored_ready", 32'(rast_ready), 32'd1);
`else
    chk("sw_post_ready", 32'(rast_ready), 32'd1);
    tick();
    chk("nc_no_clear", 32'(fb_wea), 32'd0);
`endif

    // Dropped frames while drawing.
    vsync = 1'b0;
    tick(); tick(); tick();
    chk("drop_1", 32'(dropped), 32'd1);
    vsync = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 2; i++) begin
      vsync = 1'b0;
      tick(); tick(); tick();
      vsync = 1'b1;
      tick(); tick(); tick();
    end
    chk("drop_3", 32'(dropped), 32'd3);
    chk("drop_front", 32'(front_sel), 32'd1);
    chk("drop_swap", 32'(swap_pulse), 32'd0);
    for (int i = 0; i < 251; i++) vs_pulse();
    tick(); tick(); tick();
    chk("drop_254", 32'(dropped), 32'hFE);
    vs_pulse();
    tick(); tick(); tick();
    chk("drop_255", 32'(dropped), 32'hFF);
    for (int i = 0; i < 45; i++) vs_pulse();
    tick(); tick(); tick();
    chk("drop_sat", 32'(dropped), 32'hFF);
    chk("drop_sat_front", 32'(front_sel), 32'd1);

    // Reset in the middle of a frame.
    do_swap(1'b0);
`ifdef FB_SEQ_CLEAR_EN
    run_clear(1'b0);
    do_swap(1'b1);
    for (int k = 0; k < 10; k++) tick();
    chk("mid_addr9", 32'(fb_addra), 32'd9);
    rst = 1'b1;
    tick();
    chk("mrst_wea", 32'(fb_wea), 32'd0);
    chk("mrst_front", 32'(front_sel), 32'd0);
    chk("mrst_drop", 32'(dropped), 32'd0);
    rst = 1'b0;
    run_clear(1'b0);
    chk("mrst_front_after", 32'(front_sel), 32'd0);
`else
    do_swap(1'b1);
    rast_valid = 1'b1; rast_addr = 17'd3; rast_data = 8'h77;
    rst = 1'b1;
    tick();
    chk("mrst_wea", 32'(fb_wea), 32'd0);
    chk("mrst_front", 32'(front_sel), 32'd0);
    chk("mrst_drop", 32'(dropped), 32'd0);
    chk("mrst_ready", 32'(rast_ready), 32'd1);
    rst = 1'b0;
    tick();
    chk("mrst_wr_wea", 32'(fb_wea), 32'd1);
    chk("mrst_wr_addr", 32'(fb_addra), 32'd3);
    chk("mrst_wr_data", 32'(fb_dina), 32'h77);
    rast_valid = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
